fifo_serial_tx: RTL and testbench



---
 rtl/fifo_serial_pkg.sv | 21 ++
 rtl/fifo_serial_tx_if.sv | 24 ++
 rtl/fifo_serial_tx_baud_tick_gen.sv | 39 +++
 rtl/fifo_serial_tx.sv | 132 +++++++++++++
 tb/tb_fifo_serial_tx.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_serial_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter.
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN (adds the PARITY state).
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef FIFO_SERIAL_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// Handshake bundle between the FIFO read port, the enable and the TX pin.
// master: the transmitter; slave: FIFO / system side.
interface fifo_serial_tx_if;
    import fifo_serial_pkg::*;

    logic                 tx_en;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_rd;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  tx_en, fifo_empty, fifo_data,
        output fifo_rd, tx, busy, frame_done
    );

    modport slave (
        output tx_en, fifo_empty, fifo_data,
        input  fifo_rd, tx, busy, frame_done
    );

endinterface

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while run is high and wraps on
// terminal count; tick_next flags the cycle before tick so a caller can
// register a pulse that lands exactly on the terminal-count cycle.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic tick,
    output logic tick_next
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick      = run && (cnt_q == TC);
    assign tick_next = run && (cnt_q == PRE);

    // Next count: clear dominates, otherwise advance and wrap while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from the 16x8 FIFO and sends each as start, 8 data bits LSB
// first, optional even parity, stop. All outputs are registered from the
// next-state values so they line up with the state they belong to.
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN.
//
//   state  | meaning
//   IDLE   | line high, waiting for tx_en with FIFO not empty
//   FETCH  | one-cycle pop strobe to the FIFO
//   LOAD   | FIFO read data captured into the shift register
//   START  | start bit for one bit period
//   DATA   | shift[0] on the line, 8 bit periods
//   PARITY | even parity of the byte (feature builds only)
//   STOP   | stop bit; frame_done on its last cycle, then refetch or idle
module fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    fifo_serial_tx_if.master bus
);
    import fifo_serial_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              fifo_rd_q, busy_q, frame_done_q;
    logic              cnt_clear, tick, tick_next;
    logic              start_ok;

    assign start_ok  = bus.tx_en && !bus.fifo_empty;
    assign cnt_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (cnt_clear),
        .run       (!cnt_clear),
        .tick      (tick),
        .tick_next (tick_next)
    );

`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic parity_q;

    // Parity is taken from the FIFO word in the same cycle the shifter loads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                parity_q <= 1'b0;
        else if (state_q == ST_LOAD) parity_q <= ^bus.fifo_data;
    end
`endif

    // Next-state, shift register and bit index.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d = bus.fifo_data;
                state_d = ST_START;
            end
            ST_START: if (tick) begin
                bit_idx_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: if (tick) begin
                shift_d = shift_q >> 1;
                if (bit_idx_q == LAST_BIT) begin
                    bit_idx_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                    state_d   = ST_PARITY;
`else
                    state_d   = ST_STOP;
`endif
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            ST_STOP: if (tick) state_d = start_ok ? ST_FETCH : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level for the state being entered.
    always_comb begin
        tx_d = STOP_BIT;
        case (state_d)
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = STOP_BIT;
        endcase
    end

    // State and registered outputs; reset aborts any frame and idles the line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            tx_q         <= STOP_BIT;
            fifo_rd_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            fifo_rd_q    <= (state_d == ST_FETCH);
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= (state_q == ST_STOP) && tick_next;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd    = fifo_rd_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: small FIFO model, expected-byte scoreboard and a
// line decoder that samples every cycle on the falling clock edge.
module tb_fifo_serial_tx;
    import fifo_serial_pkg::*;

    localparam int C = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       start_b;
        logic       stop_b;
        int         unstable;
        int         busy_bad;
        int         fd_cnt;
        int         fd_pos;
        int         gap;
        bit         timeout;
    } frame_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    fifo_serial_tx_if bus ();

    fifo_serial_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] fifo_mem [0:255];
    int push_cnt = 0;
    int pop_cnt = 0;
    int rd_count = 0;
    int bad_pop = 0;
    logic [7:0] exp_q [$];

    assign bus.fifo_empty = (push_cnt == pop_cnt);

    // FIFO read port model: registered data, valid the cycle after the pop.
    always @(posedge clock) begin
        if (bus.fifo_rd === 1'b1) begin
            rd_count <= rd_count + 1;
            if (push_cnt == pop_cnt) begin
                bad_pop <= bad_pop + 1;
            end else begin
                bus.fifo_data <= fifo_mem[pop_cnt & 255];
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, checks %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[push_cnt & 255] = b;
        exp_q.push_back(b);
        push_cnt = push_cnt + 1;
    endtask

    // Waits (bounded) for a start bit and samples the whole frame cycle by cycle.
    task automatic recv_frame(output frame_t f);
        logic [10:0] bits;
        logic v;
        bits = '1;
        f.gap = 0; f.timeout = 1'b0; f.unstable = 0; f.busy_bad = 0;
        f.fd_cnt = 0; f.fd_pos = -1; f.data = '0; f.par = 1'b0;
        f.start_b = 1'b1; f.stop_b = 1'b0;
        @(negedge clock);
        while (bus.tx !== 1'b0 && f.gap < 400) begin
            f.gap++;
            @(negedge clock);
        end
        if (f.gap >= 400) begin
            f.timeout = 1'b1;
            return;
        end
        for (int b = 0; b < FB; b++) begin
            for (int k = 0; k < C; k++) begin
                if (b != 0 || k != 0) @(negedge clock);
                v = bus.tx;
                if (k == 0) bits[b] = v;
                else if (v !== bits[b]) f.unstable++;
                if (bus.busy !== 1'b1) f.busy_bad++;
                if (bus.frame_done === 1'b1) begin
                    f.fd_cnt++;
                    f.fd_pos = b * C + k;
                end
            end
        end
        f.start_b = bits[0];
        f.data    = bits[8:1];
        f.par     = bits[9];
        f.stop_b  = bits[FB-1];
    endtask

    task automatic test_reset();
        int bad;
        reset_n = 1'b0;
        bus.tx_en = 1'b1;
        repeat (3) @(negedge clock);
        total_cnt++; if (bus.tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus.tx); else pass_cnt++;
        total_cnt++; if (bus.fifo_rd !== 1'b0) $display("FAIL reset_fifo_rd: got %b want 0", bus.fifo_rd); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); else pass_cnt++;
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL idle_empty_line: got %0d bad cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (rd_count !== 0) $display("FAIL idle_empty_pops: got %0d want 0", rd_count); else pass_cnt++;
    endtask

    task automatic test_single_byte();
        frame_t f;
        logic [7:0] e;
        int rd0;
        rd0 = rd_count;
        push_byte(8'hA5);
        recv_frame(f);
        e = exp_q.pop_front();
        total_cnt++; if (f.timeout !== 1'b0) $display("FAIL single_timeout: got %b want 0", f.timeout); else pass_cnt++;
        total_cnt++; if (f.gap !== 2) $display("FAIL single_latency: got %0d high cycles want 2", f.gap); else pass_cnt++;
        total_cnt++; if (f.start_b !== 1'b0) $display("FAIL single_start: got %b want 0", f.start_b); else pass_cnt++;
        total_cnt++; if (f.data !== e) $display("FAIL single_data: got %h want %h", f.data, e); else pass_cnt++;
        total_cnt++; if (f.stop_b !== 1'b1) $display("FAIL single_stop: got %b want 1", f.stop_b); else pass_cnt++;
        total_cnt++; if (f.unstable !== 0) $display("FAIL single_bit_width: got %0d glitches want 0", f.unstable); else pass_cnt++;
        total_cnt++; if (f.busy_bad !== 0) $display("FAIL single_busy: got %0d low cycles want 0", f.busy_bad); else pass_cnt++;
        total_cnt++; if (f.fd_cnt !== 1) $display("FAIL single_done_cnt: got %0d want 1", f.fd_cnt); else pass_cnt++;
        total_cnt++; if (f.fd_pos !== FB*C-1) $display("FAIL single_done_pos: got %0d want %0d", f.fd_pos, FB*C-1); else pass_cnt++;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        total_cnt++; if (f.par !== ^e) $display("FAIL single_parity: got %b want %b", f.par, ^e); else pass_cnt++;
`endif
        @(negedge clock);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.tx !== 1'b1) $display("FAIL single_tx_after: got %b want 1", bus.tx); else pass_cnt++;
        total_cnt++; if (rd_count - rd0 !== 1) $display("FAIL single_pops: got %0d want 1", rd_count - rd0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        frame_t f1, f2;
        logic [7:0] e1, e2;
        int rd0;
        rd0 = rd_count;
        push_byte(8'h00);
        push_byte(8'hFF);
        recv_frame(f1);
        recv_frame(f2);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        total_cnt++; if (f1.timeout !== 1'b0 || f2.timeout !== 1'b0) $display("FAIL b2b_timeout: got %b/%b want 0/0", f1.timeout, f2.timeout); else pass_cnt++;
        total_cnt++; if (f1.data !== e1) $display("FAIL b2b_data1: got %h want %h", f1.data, e1); else pass_cnt++;
        total_cnt++; if (f2.gap !== 2) $display("FAIL b2b_gap: got %0d high cycles want 2", f2.gap); else pass_cnt++;
        total_cnt++; if (f2.data !== e2) $display("FAIL b2b_data2: got %h want %h", f2.data, e2); else pass_cnt++;
        total_cnt++; if (f1.unstable + f2.unstable !== 0) $display("FAIL b2b_bit_width: got %0d glitches want 0", f1.unstable + f2.unstable); else pass_cnt++;
        total_cnt++; if (f1.stop_b !== 1'b1 || f2.start_b !== 1'b0) $display("FAIL b2b_framing: got stop %b start %b want 1 0", f1.stop_b, f2.start_b); else pass_cnt++;
        total_cnt++; if (f1.busy_bad + f2.busy_bad !== 0) $display("FAIL b2b_busy: got %0d low cycles want 0", f1.busy_bad + f2.busy_bad); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (rd_count - rd0 !== 2) $display("FAIL b2b_pops: got %0d want 2", rd_count - rd0); else pass_cnt++;
    endtask

    task automatic test_pause();
        frame_t f1, f2;
        logic [7:0] e;
        int rd0, bad;
        rd0 = rd_count;
        push_byte(8'h3C);
        push_byte(8'h5A);
        fork
            recv_frame(f1);
            begin
                int n;
                n = 0;
                while (bus.tx !== 1'b0 && n < 400) begin
                    @(negedge clock);
                    n++;
                end
                repeat (C*4 + 1) @(negedge clock);
                bus.tx_en = 1'b0;
            end
        join
        e = exp_q.pop_front();
        total_cnt++; if (f1.timeout !== 1'b0) $display("FAIL pause_timeout: got %b want 0", f1.timeout); else pass_cnt++;
        total_cnt++; if (f1.data !== e) $display("FAIL pause_data: got %h want %h", f1.data, e); else pass_cnt++;
        total_cnt++; if (f1.unstable !== 0 || f1.stop_b !== 1'b1) $display("FAIL pause_complete: got %0d glitches stop %b want 0 1", f1.unstable, f1.stop_b); else pass_cnt++;
        bad = 0;
        repeat (3*FB*C) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL pause_idle: got %0d bad cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (rd_count - rd0 !== 1) $display("FAIL pause_pops: got %0d want 1", rd_count - rd0); else pass_cnt++;
        bus.tx_en = 1'b1;
        recv_frame(f2);
        e = exp_q.pop_front();
        total_cnt++; if (f2.gap !== 2) $display("FAIL resume_latency: got %0d want 2", f2.gap); else pass_cnt++;
        total_cnt++; if (f2.data !== e) $display("FAIL resume_data: got %h want %h", f2.data, e); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (rd_count - rd0 !== 2) $display("FAIL resume_pops: got %0d want 2", rd_count - rd0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        frame_t f;
        logic [7:0] e;
        int n, rd0;
        rd0 = rd_count;
        push_byte(8'h96);
        push_byte(8'h81);
        n = 0;
        while (bus.tx !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        total_cnt++; if (n >= 400) $display("FAIL midrst_start_timeout: got %0d cycles want <400", n); else pass_cnt++;
        repeat (C*6 + 1) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        total_cnt++; if (bus.tx !== 1'b1) $display("FAIL midrst_tx: got %b want 1", bus.tx); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else pass_cnt++;
        void'(exp_q.pop_front());
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        recv_frame(f);
        e = exp_q.pop_front();
        total_cnt++; if (f.timeout !== 1'b0) $display("FAIL midrst_timeout: got %b want 0", f.timeout); else pass_cnt++;
        total_cnt++; if (f.data !== e) $display("FAIL midrst_data: got %h want %h", f.data, e); else pass_cnt++;
        total_cnt++; if (f.unstable !== 0 || f.fd_cnt !== 1) $display("FAIL midrst_frame: got %0d glitches %0d done want 0 1", f.unstable, f.fd_cnt); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (rd_count - rd0 !== 2) $display("FAIL midrst_pops: got %0d want 2", rd_count - rd0); else pass_cnt++;
    endtask

`ifdef FIFO_SERIAL_TX_PARITY_EN
    task automatic test_parity();
        frame_t f1, f2;
        logic [7:0] e1, e2;
        push_byte(8'hA5);
        push_byte(8'h07);
        recv_frame(f1);
        recv_frame(f2);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        total_cnt++; if (f1.data !== e1 || f2.data !== e2) $display("FAIL parity_data: got %h %h want %h %h", f1.data, f2.data, e1, e2); else pass_cnt++;
        total_cnt++; if (f1.par !== 1'b0) $display("FAIL parity_a5: got %b want 0", f1.par); else pass_cnt++;
        total_cnt++; if (f2.par !== 1'b1) $display("FAIL parity_07: got %b want 1", f2.par); else pass_cnt++;
        total_cnt++; if (f1.fd_pos !== 43 || f2.fd_pos !== 43) $display("FAIL parity_length: got %0d %0d want 43 43", f1.fd_pos, f2.fd_pos); else pass_cnt++;
        total_cnt++; if (f1.unstable + f2.unstable !== 0) $display("FAIL parity_bit_width: got %0d want 0", f1.unstable + f2.unstable); else pass_cnt++;
    endtask
`endif

    initial begin
        bus.tx_en = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_pause();
        test_reset_mid_frame();
`ifdef FIFO_SERIAL_TX_PARITY_EN
        test_parity();
`endif
        repeat (5) @(negedge clock);
        total_cnt++; if (bad_pop !== 0) $display("FAIL pop_when_empty: got %0d want 0", bad_pop); else pass_cnt++;
        total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
